// File: rtl/shared_bus_arbiter.sv
// Round-robin single-driver resolver for a shared bus: one registered owner at a time,
// bounded hold time, and a saturating count of cycles with more than one requester.
//
// state | meaning
// IDLE  | no owner; bus_out held at zero, next grant searched from ptr
// OWNED | owner drives bus_out; hold counts consecutive cycles of ownership
module shared_bus_arbiter #(
    parameter int N        = 4,
    parameter int W        = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] data_in,
    output logic [N-1:0]   grant,
    output logic           bus_valid,
    output logic [W-1:0]   bus_out,
    output logic           conflict,
    output logic [15:0]    conflict_cnt
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_ONE = HW'(1);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t        state, nxt_state;
    logic [IW-1:0] owner, nxt_owner, ptr, owner_inc;
    logic [HW-1:0] hold, nxt_hold;
    logic [N-1:0]  owner_mask, others, nxt_grant;
    logic          multi_req;

    // First set bit of mask at or after start, wrapping modulo N.
    function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] mask, input logic [IW-1:0] start);
        logic [IW-1:0] pick;
        logic          found;
        int            idx;
        pick  = start;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(start) + k) % N;
            if (!found && mask[idx]) begin
                pick  = IW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        nxt_state  = state;
        nxt_owner  = owner;
        nxt_hold   = hold;
        owner_mask = N'(1) << owner;
        others     = req & ~owner_mask;
        owner_inc  = (int'(owner) == N - 1) ? '0 : owner + 1'b1;
        multi_req  = (req & (req - 1'b1)) != '0;

        case (state)
            IDLE: begin
                if (req != '0) begin
                    nxt_state = OWNED;
                    nxt_owner = rr_pick(req, ptr);
                    nxt_hold  = HOLD_ONE;
                end
            end
            OWNED: begin
                if (!req[owner]) begin
                    if (others != '0) begin
                        nxt_owner = rr_pick(others, owner_inc);
                        nxt_hold  = HOLD_ONE;
                    end else begin
                        nxt_state = IDLE;
                        nxt_hold  = '0;
                    end
                end else if (hold == HOLD_MAX) begin
                    // Hold limit: hand over only if someone else is waiting.
                    if (others != '0) nxt_owner = rr_pick(others, owner_inc);
                    nxt_hold = HOLD_ONE;
                end else begin
                    nxt_hold = hold + 1'b1;
                end
            end
            default: begin
                nxt_state = IDLE;
                nxt_hold  = '0;
            end
        endcase

        nxt_grant = (nxt_state == OWNED) ? (N'(1) << nxt_owner) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            owner        <= '0;
            hold         <= '0;
            ptr          <= '0;
            grant        <= '0;
            bus_valid    <= 1'b0;
            bus_out      <= '0;
            conflict     <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            state     <= nxt_state;
            owner     <= nxt_owner;
            hold      <= nxt_hold;
            grant     <= nxt_grant;
            bus_valid <= (nxt_state == OWNED);
            bus_out   <= (nxt_state == OWNED) ? data_in[int'(nxt_owner)*W +: W] : '0;
            if (nxt_state == OWNED)
                ptr <= (int'(nxt_owner) == N - 1) ? '0 : nxt_owner + 1'b1;
            conflict <= multi_req;
            if (multi_req && conflict_cnt != 16'hFFFF)
                conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Directed bench for shared_bus_arbiter (N=4, W=8, MAX_HOLD=4) with a scoreboard of
// per-edge expectations from a behavioural model plus explicit constant checks.
module tb_shared_bus_arbiter;
    localparam int N = 4;
    localparam int W = 8;
    localparam int MH = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] data_in = '0;
    logic [N-1:0]   grant;
    logic           bus_valid;
    logic [W-1:0]   bus_out;
    logic           conflict;
    logic [15:0]    conflict_cnt;

    shared_bus_arbiter #(.N(N), .W(W), .MAX_HOLD(MH)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in),
        .grant(grant), .bus_valid(bus_valid), .bus_out(bus_out),
        .conflict(conflict), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  grant;
        logic        valid;
        logic [7:0]  bus;
        logic        conflict;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    int m_owned = 0;
    int m_o = 0;
    int m_h = 0;
    int m_ptr = 0;
    int m_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int search(input logic [3:0] m, input int start);
        for (int k = 0; k < N; k++) begin
            if (m[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owned = 0; m_o = 0; m_h = 0; m_ptr = 0; m_cnt = 0;
        q.delete();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_grant"}, 32'(grant), 32'h0);
        chk({tag, "_valid"}, 32'(bus_valid), 32'h0);
        chk({tag, "_bus"}, 32'(bus_out), 32'h0);
        chk({tag, "_conflict"}, 32'(conflict), 32'h0);
        chk({tag, "_cnt"}, 32'(conflict_cnt), 32'h0);
    endtask

    // Drive one cycle of stimulus, push the model's expectation, compare after the edge.
    task automatic cycle(input logic [3:0] r, input logic [31:0] d);
        logic [3:0] oth;
        exp_t e, got;
        @(negedge clk);
        req = r;
        data_in = d;
        oth = r;
        if (m_owned != 0) oth[m_o] = 1'b0;
        if (m_owned == 0) begin
            if (r != 4'b0) begin m_o = search(r, m_ptr); m_owned = 1; m_h = 1; end
        end else if (!r[m_o]) begin
            if (oth != 4'b0) begin m_o = search(oth, (m_o + 1) % N); m_h = 1; end
            else begin m_owned = 0; m_h = 0; end
        end else if (m_h == MH) begin
            if (oth != 4'b0) m_o = search(oth, (m_o + 1) % N);
            m_h = 1;
        end else begin
            m_h++;
        end
        if (m_owned != 0) m_ptr = (m_o + 1) % N;
        if ($countones(r) >= 2 && m_cnt < 65535) m_cnt++;
        e.grant    = (m_owned != 0) ? (4'b0001 << m_o) : 4'b0;
        e.valid    = (m_owned != 0);
        e.bus      = (m_owned != 0) ? d[m_o*8 +: 8] : 8'h00;
        e.conflict = ($countones(r) >= 2);
        e.cnt      = 16'(m_cnt);
        q.push_back(e);
        @(posedge clk);
        #1;
        got = q.pop_front();
        chk("sb_grant", 32'(grant), 32'(got.grant));
        chk("sb_valid", 32'(bus_valid), 32'(got.valid));
        chk("sb_bus", 32'(bus_out), 32'(got.bus));
        chk("sb_conflict", 32'(conflict), 32'(got.conflict));
        chk("sb_cnt", 32'(conflict_cnt), 32'(got.cnt));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req = '0;
        #1;
        check_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held low with random activity on the inputs
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req = 4'($urandom);
            data_in = $urandom;
            @(posedge clk);
            #1;
            check_zero("rst_hold");
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Asynchronous reset while requester 2 owns the bus
        cycle(4'b0100, 32'h0077_0000);
        chk("own2_grant", 32'(grant), 32'h4);
        chk("own2_bus", 32'(bus_out), 32'h77);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_grant", 32'(grant), 32'h0);
        chk("async_bus", 32'(bus_out), 32'h0);
        chk("async_valid", 32'(bus_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Single requester, data tracking, release
        cycle(4'b0010, 32'h0000_A500);
        chk("single_grant", 32'(grant), 32'h2);
        chk("single_valid", 32'(bus_valid), 32'h1);
        chk("single_bus", 32'(bus_out), 32'hA5);
        cycle(4'b0010, 32'h0000_3C00);
        chk("single_data", 32'(bus_out), 32'h3C);
        cycle(4'b0000, 32'h0000_3C00);
        chk("drop_grant", 32'(grant), 32'h0);
        chk("drop_bus", 32'(bus_out), 32'h0);

        // Round robin with all requesting from reset
        do_reset();
        for (int i = 0; i < 17; i++) begin
            cycle(4'b1111, $urandom);
            chk("rr_grant", 32'(grant), 32'(4'b0001 << ((i / 4) % 4)));
            chk("rr_conflict", 32'(conflict), 32'h1);
            chk("rr_cnt", 32'(conflict_cnt), 32'(i + 1));
        end

        // Release handover without an idle gap
        cycle(4'b0000, $urandom);
        cycle(4'b0001, 32'h0000_0011);
        chk("ho_own0", 32'(grant), 32'h1);
        cycle(4'b0100, 32'h0022_0011);
        chk("ho_grant", 32'(grant), 32'h4);
        chk("ho_valid", 32'(bus_valid), 32'h1);
        chk("ho_conflict", 32'(conflict), 32'h0);
        chk("ho_bus", 32'(bus_out), 32'h22);

        // Hold limit with no competitor
        for (int i = 0; i < 10; i++) begin
            cycle(4'b1000, $urandom);
            chk("hold_grant", 32'(grant), 32'h8);
        end

        // Random mix through the scoreboard
        for (int i = 0; i < 60; i++) cycle(4'($urandom), $urandom);

        // Counter saturation
        do_reset();
        @(negedge clk);
        req = 4'b0011;
        repeat (65533) @(posedge clk);
        #1;
        chk("sat_pre", 32'(conflict_cnt), 32'hFFFD);
        @(posedge clk); #1;
        chk("sat_fffe", 32'(conflict_cnt), 32'hFFFE);
        @(posedge clk); #1;
        chk("sat_ffff", 32'(conflict_cnt), 32'hFFFF);
        @(posedge clk); #1;
        chk("sat_stay", 32'(conflict_cnt), 32'hFFFF);
        @(posedge clk); #1;
        chk("sat_stay2", 32'(conflict_cnt), 32'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
